// File: rtl/sd_cmd_assembler.sv
// Packs UART bytes into 48-bit SD command frames, checks framing bits and CRC7,
// and hands good frames downstream over valid/ready; bad frames raise status pulses.
module sd_cmd_assembler #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [47:0] cmd_frame,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        crc_error,
    output logic        frame_error,
    output logic        timeout,
    output logic        overrun
);
    localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic [6:0]    crc_q;
    logic [6:0]    crc_d;
    logic [6:0]    crc_first_d;
    logic [GW-1:0] gap_q;
    logic [47:0]   frame_q;
    logic          valid_q;
    logic          crc_err_q;
    logic          frame_err_q;
    logic          timeout_q;
    logic          overrun_q;
    logic          handshake;
    logic          accept_new;

    // Serial CRC7 (x^7 + x^3 + 1), one byte MSB first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] c_in, input logic [7:0] b);
        logic [6:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ b[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign crc_d       = crc7_byte(crc_q, rx_data);
    assign crc_first_d = crc7_byte(7'h00, rx_data);
    assign handshake   = (state_q == HOLD) && valid_q && cmd_ready;
    // A byte arriving with the handshake is treated as if the block were already idle.
    assign accept_new  = rx_valid && ((state_q == IDLE) || handshake);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            crc_q       <= 7'h00;
            gap_q       <= '0;
            frame_q     <= 48'h0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;

            if (handshake) begin
                valid_q <= 1'b0;
                state_q <= IDLE;
            end
            if (state_q == HOLD && rx_valid && !cmd_ready)
                overrun_q <= 1'b1;

            if (accept_new) begin
                if (rx_data[7:6] == 2'b01) begin
                    frame_q[47:40] <= rx_data;
                    crc_q          <= crc_first_d;
                    cnt_q          <= 3'd1;
                    gap_q          <= '0;
                    state_q        <= COLLECT;
                end else begin
                    frame_err_q <= 1'b1;
                end
            end

            if (state_q == COLLECT) begin
                if (rx_valid) begin
                    gap_q <= '0;
                    if (cnt_q == 3'd5) begin
                        cnt_q   <= 3'd0;
                        state_q <= IDLE;
                        if (!rx_data[0]) begin
                            frame_err_q <= 1'b1;
                        end else if (rx_data[7:1] != crc_q) begin
                            crc_err_q <= 1'b1;
                        end else begin
                            frame_q[7:0] <= rx_data;
                            valid_q      <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end else begin
                        case (cnt_q)
                            3'd1:    frame_q[39:32] <= rx_data;
                            3'd2:    frame_q[31:24] <= rx_data;
                            3'd3:    frame_q[23:16] <= rx_data;
                            3'd4:    frame_q[15:8]  <= rx_data;
                            default: ;
                        endcase
                        crc_q <= crc_d;
                        cnt_q <= cnt_q + 3'd1;
                    end
                end else if (TIMEOUT_CYCLES != 0 && gap_q == GAP_LAST) begin
                    timeout_q <= 1'b1;
                    gap_q     <= '0;
                    cnt_q     <= 3'd0;
                    state_q   <= IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    gap_q <= gap_q + GW'(1);
                end
            end
        end
    end

    assign cmd_frame   = frame_q;
    assign cmd_valid   = valid_q;
    assign crc_error   = crc_err_q;
    assign frame_error = frame_err_q;
    assign timeout     = timeout_q;
    assign overrun     = overrun_q;
endmodule
